riscv_run_ctrl_monitor: RTL and testbench
=========================================

# riscv_run_ctrl_monitor

Run-control and register-display unit sitting between board inputs and the `RISCV_Pipeline` core. It gates the core's clock-enable for free-run, bounded-run and single-step execution, counts executed cycles, and drives a registered `DISP_W`-bit display from the core's register-file debug read port. This generalises the fixed start/SW/OUT scheme: the register count, display width and counter width are parametrised, and it adds a cycle limit, a step mode, half-word selection, auto-scan and a cycle-count display.

## Interface
- `XLEN`, 32: register width of the core; must satisfy `XLEN >= 2*DISP_W`.
- `NREGS`, 32: number of architectural registers; `SEL_W = $clog2(NREGS)`.
- `DISP_W`, 16: display width.
- `CNT_W`, 32: cycle counter width.
- `SCAN_DIV`, 4: cycles per register in auto-scan mode; must be >= 1.

Ports (`name direction width meaning`):
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: level; begin or restart a free or bounded run.
- `step` in 1: level; execute exactly one core cycle.
- `halt` in 1: level; stop execution.
- `run_limit` in `CNT_W`: cycle budget per run; 0 means unlimited. Sampled continuously.
- `SW` in `SEL_W`: manual register select.
- `mode` in 2: display mode. 00 = manual low half, 01 = manual high half, 10 = auto-scan, 11 = cycle count.
- `rf_raddr` out `SEL_W`: combinational debug read address to the core.
- `rf_rdata` in `XLEN`: combinational debug read data from the core.
- `cpu_en` out 1: core enable. 1 only in RUN or STEP.
- `OUT` out `DISP_W`: registered display value.
- `cycle_cnt` out `CNT_W`: count of cycles with `cpu_en = 1`.
- `scan_idx` out `SEL_W`: current auto-scan register.
- `state` out 2: IDLE = 00, RUN = 01, STEP = 10, DONE = 11.

## Operation
- **Reset values:** `state` = IDLE, `cpu_en` = 0, `cycle_cnt` = 0, `OUT` = 0, `scan_idx` = 0, scan divider = 0. Reset overrides all other inputs, including in the middle of a run or step.
- **Input priority:** evaluated each cycle as `halt` > `start` > `step`.
- **IDLE**
  - `start` → RUN and clear `cycle_cnt`.
  - `step` → STEP; `cycle_cnt` is not cleared.
- **RUN**
  - `halt` → IDLE.
  - If `run_limit != 0` and this cycle's increment makes `cycle_cnt == run_limit` → DONE.
  - `start` held while in RUN has no effect.
- **STEP:** lasts exactly one cycle, then → IDLE. `halt` in the STEP cycle still lets that cycle complete (`cpu_en` is already 1), then → IDLE. Holding `step` high re-enters STEP every other cycle (STEP, IDLE, STEP…).
- **DONE**
  - `start` → RUN and clear `cycle_cnt`.
  - `halt` → IDLE, keeping `cycle_cnt`.
  - `step` is ignored.
- **`cpu_en`:** decoded from the registered `state` (Moore output).
- **`cycle_cnt`:** increments by 1 in every cycle where `cpu_en = 1`. Saturates at all-ones with no wrap. The clear on RUN entry takes precedence over the increment.
- **`rf_raddr`:** equals `scan_idx` when `mode = 10`, otherwise `SW`.
- **`OUT` next value, registered every cycle:**
  - mode 00: `rf_rdata[DISP_W-1:0]`
  - mode 01: `rf_rdata[2*DISP_W-1:DISP_W]`
  - mode 10: `rf_rdata[DISP_W-1:0]`
  - mode 11: `cycle_cnt[DISP_W-1:0]`, i.e. the pre-update value in that cycle.
- **Auto-scan:** the divider counts 0..`SCAN_DIV-1`. When it reaches `SCAN_DIV-1`, `scan_idx` increments and wraps `NREGS-1` → 0. While `mode != 10`, both the divider and `scan_idx` are held at 0, so each scan restarts at x0.

## Timing
- `start` sampled at edge N → `state` = RUN and `cpu_en` = 1 after edge N. `cycle_cnt` reads 1 after edge N+1.
- Bounded run with limit L: `cpu_en` is high for exactly L cycles, then `state` = DONE and `cycle_cnt` = L.
- `halt` sampled at edge N → `cpu_en` = 0 after edge N. The count includes every cycle up to edge N.
- Display latency: a change on `SW` or `mode` is visible on `OUT` after 1 edge, given a combinational `rf_rdata`.
- Auto-scan: `scan_idx` advances every `SCAN_DIV` cycles. `OUT` shows register k one cycle after `scan_idx` = k.
- Limit change during RUN: the new `run_limit` takes effect immediately. If `cycle_cnt` is already >= the new limit, the run continues until `halt` or saturation.

## Test plan
- Reset, `run_limit` = 0, pulse `start` for 1 cycle, wait 40 cycles, raise `halt` → `cpu_en` high for exactly 40 cycles, `cycle_cnt` = 40, `state` = IDLE.
- `run_limit` = 10, pulse `start` → `cpu_en` high 10 cycles, `state` = DONE, `cycle_cnt` = 10. Pulse `start` again → count restarts at 0, reaches 10, DONE.
- 3 isolated `step` pulses from IDLE → 3 single-cycle `cpu_en` pulses, `cycle_cnt` = 3. Assert `halt` and `step` in the same cycle → no step.
- Core holds x5 = 0xDEAD_BEEF; `SW` = 5, mode 00 → `OUT` = 0xBEEF. Mode 01 → `OUT` = 0xDEAD one cycle later. Mode 11 → `OUT` tracks `cycle_cnt[15:0]`.
- Mode 10 with `SCAN_DIV` = 4, `NREGS` = 32 → `scan_idx` steps 0..31 every 4 cycles, wraps to 0 after 128 cycles. Leaving mode 10 resets `scan_idx` to 0.
- Assert `reset` mid-RUN with `cycle_cnt` = 7 → next cycle `state` = IDLE, `cpu_en` = 0, `cycle_cnt` = 0, `OUT` = 0. Separately, `CNT_W` = 4 with an unlimited run → `cycle_cnt` saturates at 15.

Source files
------------

// File: rtl/riscv_run_ctrl_monitor.sv
// Run control and register display for the RISC-V pipeline core: gates the core
// clock-enable for free, bounded and single-step runs, counts cycles, drives the display.
module riscv_run_ctrl_monitor #(
    parameter  int XLEN     = 32,
    parameter  int NREGS    = 32,
    parameter  int DISP_W   = 16,
    parameter  int CNT_W    = 32,
    parameter  int SCAN_DIV = 4,
    localparam int SEL_W    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic             halt,
    input  logic [CNT_W-1:0] run_limit,
    input  logic [SEL_W-1:0] SW,
    input  logic [1:0]       mode,
    output logic [SEL_W-1:0] rf_raddr,
    input  logic [XLEN-1:0]  rf_rdata,
    output logic             cpu_en,
    output logic [DISP_W-1:0] OUT,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [SEL_W-1:0] scan_idx,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        DONE = 2'b11
    } state_e;

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_e            cur_state;
    state_e            nxt_state;
    logic              run_entry;
    logic [CNT_W-1:0]  cnt_inc;
    logic [DIV_W-1:0]  scan_div;
    logic [DISP_W-1:0] out_nxt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) cur_state <= IDLE;
        else       cur_state <= nxt_state;
    end

    // Saturating increment; also feeds the limit comparison so DONE lands on the L-th cycle.
    always_comb begin
        cnt_inc = cycle_cnt;
        if (cpu_en && (cycle_cnt != '1)) cnt_inc = cycle_cnt + CNT_W'(1);
    end

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        nxt_state = cur_state;
        run_entry = 1'b0;
        unique case (cur_state)
            IDLE: begin
                if (halt)       nxt_state = IDLE;
                else if (start) begin
                    nxt_state = RUN;
                    run_entry = 1'b1;
                end
                else if (step)  nxt_state = STEP;
            end
            RUN: begin
                if (halt)                                            nxt_state = IDLE;
                else if ((run_limit != '0) && (cnt_inc == run_limit)) nxt_state = DONE;
            end
            STEP: nxt_state = IDLE;
            DONE: begin
                if (halt)       nxt_state = IDLE;
                else if (start) begin
                    nxt_state = RUN;
                    run_entry = 1'b1;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        cpu_en = 1'b0;
        unique case (cur_state)
            RUN, STEP: cpu_en = 1'b1;
            default:   cpu_en = 1'b0;
        endcase
    end

    assign state = cur_state;

    always_ff @(posedge clk) begin
        if (reset)          cycle_cnt <= '0;
        else if (run_entry) cycle_cnt <= '0;
        else                cycle_cnt <= cnt_inc;
    end

    // The scan divider and index stay parked at zero outside auto-scan so each scan starts at x0.
    always_ff @(posedge clk) begin
        if (reset || (mode != 2'b10)) begin
            scan_div <= '0;
            scan_idx <= '0;
        end else if (scan_div == DIV_W'(SCAN_DIV - 1)) begin
            scan_div <= '0;
            scan_idx <= (scan_idx == SEL_W'(NREGS - 1)) ? '0 : scan_idx + SEL_W'(1);
        end else begin
            scan_div <= scan_div + DIV_W'(1);
        end
    end

    assign rf_raddr = (mode == 2'b10) ? scan_idx : SW;

    always_comb begin
        out_nxt = '0;
        unique case (mode)
            2'b00:   out_nxt = rf_rdata[DISP_W-1:0];
            2'b01:   out_nxt = rf_rdata[2*DISP_W-1:DISP_W];
            2'b10:   out_nxt = rf_rdata[DISP_W-1:0];
            default: out_nxt = DISP_W'(cycle_cnt);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) OUT <= '0;
        else       OUT <= out_nxt;
    end

    if (XLEN > 2 * DISP_W) begin : g_rdata_hi
        logic unused_rdata_hi;
        assign unused_rdata_hi = ^rf_rdata[XLEN-1:2*DISP_W];
    end

endmodule

// File: tb/tb_riscv_run_ctrl_monitor.sv
// Self-checking bench for riscv_run_ctrl_monitor: directed scenarios plus a randomized
// run against a cycle-level behavioural model; a second instance checks counter saturation.
module tb_riscv_run_ctrl_monitor;

    localparam int    NREGS    = 32;
    localparam int    SCAN_DIV = 4;
    localparam longint CMAX    = 64'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset, start, step, halt;
    logic [31:0] run_limit;
    logic [4:0]  sw;
    logic [1:0]  mode;

    logic [4:0]  rf_raddr, scan_idx;
    logic [31:0] rf_rdata, cycle_cnt;
    logic        cpu_en;
    logic [15:0] out;
    logic [1:0]  state;

    logic [3:0]  run_limit_sat = 4'd0;
    logic [4:0]  rf_raddr_sat, scan_idx_sat;
    logic [31:0] rf_rdata_sat;
    logic        cpu_en_sat;
    logic [15:0] out_sat;
    logic [3:0]  cycle_cnt_sat;
    logic [1:0]  state_sat;

    logic [31:0] regs [NREGS];

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int          m_state;
    longint      m_cnt;
    logic [15:0] m_out;
    int          m_ticks;

    riscv_run_ctrl_monitor dut (
        .clk(clk), .reset(reset), .start(start), .step(step), .halt(halt),
        .run_limit(run_limit), .SW(sw), .mode(mode), .rf_raddr(rf_raddr),
        .rf_rdata(rf_rdata), .cpu_en(cpu_en), .OUT(out), .cycle_cnt(cycle_cnt),
        .scan_idx(scan_idx), .state(state)
    );

    riscv_run_ctrl_monitor #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .step(step), .halt(halt),
        .run_limit(run_limit_sat), .SW(sw), .mode(mode), .rf_raddr(rf_raddr_sat),
        .rf_rdata(rf_rdata_sat), .cpu_en(cpu_en_sat), .OUT(out_sat),
        .cycle_cnt(cycle_cnt_sat), .scan_idx(scan_idx_sat), .state(state_sat)
    );

    assign rf_rdata     = regs[rf_raddr];
    assign rf_rdata_sat = regs[rf_raddr_sat];

    always #5 clk = ~clk;

    // Model of one clock edge, built from the run-control rules on pre-edge inputs.
    function automatic void model_update();
        longint cnt_after;
        int     nxt;
        int     scan_pre;
        if (reset) begin
            m_state = 0; m_cnt = 0; m_out = '0; m_ticks = 0;
            return;
        end
        scan_pre = (m_ticks / SCAN_DIV) % NREGS;
        case (mode)
            2'b00:   m_out = regs[sw][15:0];
            2'b01:   m_out = regs[sw][31:16];
            2'b10:   m_out = regs[scan_pre][15:0];
            default: m_out = m_cnt[15:0];
        endcase
        cnt_after = ((m_state == 1 || m_state == 2) && m_cnt < CMAX) ? m_cnt + 1 : m_cnt;
        nxt = m_state;
        if (m_state == 0) begin
            if (!halt && start) begin nxt = 1; cnt_after = 0; end
            else if (!halt && step) nxt = 2;
        end else if (m_state == 1) begin
            if (halt) nxt = 0;
            else if (run_limit != 0 && cnt_after == longint'(run_limit)) nxt = 3;
        end else if (m_state == 2) begin
            nxt = 0;
        end else begin
            if (halt) nxt = 0;
            else if (start) begin nxt = 1; cnt_after = 0; end
        end
        m_state = nxt;
        m_cnt   = cnt_after;
        m_ticks = (mode == 2'b10) ? m_ticks + 1 : 0;
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; step = 1'b0; halt = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; step = 1'b1; halt = 1'b0; mode = 2'b11;
        cyc();
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en: got %0b expected 0", cpu_en); end
        checks++; if (cycle_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cycle_cnt); end
        checks++; if (out !== 16'h0) begin errors++; $display("FAIL reset_out: got %0h expected 0", out); end
        checks++; if (scan_idx !== 5'd0) begin errors++; $display("FAIL reset_scan: got %0d expected 0", scan_idx); end
        reset = 1'b0; start = 1'b0; step = 1'b0; mode = 2'b00;
    endtask

    task automatic test_free_run();
        int en_cycles = 0;
        do_reset();
        run_limit = 32'd0;
        start = 1'b1; cyc(); en_cycles += int'(cpu_en);
        start = 1'b0;
        for (int i = 0; i < 39; i++) begin cyc(); en_cycles += int'(cpu_en); end
        halt = 1'b1; cyc(); en_cycles += int'(cpu_en);
        halt = 1'b0;
        checks++; if (en_cycles != 40) begin errors++; $display("FAIL free_run_en_cycles: got %0d expected 40", en_cycles); end
        checks++; if (cycle_cnt !== 32'd40) begin errors++; $display("FAIL free_run_cnt: got %0d expected 40", cycle_cnt); end
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL free_run_state: got %0d expected 0", state); end
    endtask

    task automatic test_bounded_run();
        do_reset();
        run_limit = 32'd10;
        for (int pass = 0; pass < 2; pass++) begin
            int en_cycles = 0;
            start = 1'b1; cyc(); en_cycles += int'(cpu_en);
            start = 1'b0;
            checks++; if (cycle_cnt !== 32'd0) begin errors++; $display("FAIL bounded_restart_cnt: got %0d expected 0", cycle_cnt); end
            for (int i = 0; i < 15; i++) begin cyc(); en_cycles += int'(cpu_en); end
            checks++; if (en_cycles != 10) begin errors++; $display("FAIL bounded_en_cycles: got %0d expected 10", en_cycles); end
            checks++; if (state !== 2'b11) begin errors++; $display("FAIL bounded_state: got %0d expected 3", state); end
            checks++; if (cycle_cnt !== 32'd10) begin errors++; $display("FAIL bounded_cnt: got %0d expected 10", cycle_cnt); end
        end
        // step is ignored in DONE
        step = 1'b1; cyc(); step = 1'b0;
        checks++; if (state !== 2'b11) begin errors++; $display("FAIL done_step_ignored: got %0d expected 3", state); end
        // lowering the limit below the current count mid-run does not stop the run
        run_limit = 32'd0;
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 8; i++) cyc();
        run_limit = 32'd5;
        for (int i = 0; i < 5; i++) cyc();
        checks++; if (state !== 2'b01 || cycle_cnt !== 32'd13) begin
            errors++; $display("FAIL limit_lowered: got state %0d cnt %0d expected state 1 cnt 13", state, cycle_cnt);
        end
        halt = 1'b1; cyc(); halt = 1'b0;
        run_limit = 32'd0;
    endtask

    task automatic test_step();
        int en_cycles = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step = 1'b1; cyc(); en_cycles += int'(cpu_en);
            step = 1'b0; cyc(); en_cycles += int'(cpu_en);
            cyc(); en_cycles += int'(cpu_en);
        end
        checks++; if (en_cycles != 3) begin errors++; $display("FAIL step_pulses: got %0d expected 3", en_cycles); end
        checks++; if (cycle_cnt !== 32'd3) begin errors++; $display("FAIL step_cnt: got %0d expected 3", cycle_cnt); end
        halt = 1'b1; step = 1'b1; cyc();
        halt = 1'b0; step = 1'b0;
        checks++; if (cpu_en !== 1'b0 || state !== 2'b00) begin
            errors++; $display("FAIL halt_blocks_step: got en %0b state %0d expected en 0 state 0", cpu_en, state);
        end
        step = 1'b1; cyc(); step = 1'b0; halt = 1'b1; cyc(); halt = 1'b0;
        checks++; if (state !== 2'b00 || cycle_cnt !== 32'd4) begin
            errors++; $display("FAIL halt_in_step: got state %0d cnt %0d expected state 0 cnt 4", state, cycle_cnt);
        end
        en_cycles = 0;
        step = 1'b1;
        for (int i = 0; i < 4; i++) begin cyc(); en_cycles += int'(cpu_en); end
        step = 1'b0;
        checks++; if (en_cycles != 2) begin errors++; $display("FAIL held_step: got %0d expected 2", en_cycles); end
    endtask

    task automatic test_display();
        do_reset();
        regs[5] = 32'hDEAD_BEEF;
        sw = 5'd5; mode = 2'b00; cyc();
        checks++; if (out !== 16'hBEEF) begin errors++; $display("FAIL disp_low: got %0h expected beef", out); end
        mode = 2'b01; cyc();
        checks++; if (out !== 16'hDEAD) begin errors++; $display("FAIL disp_high: got %0h expected dead", out); end
        mode = 2'b11;
        start = 1'b1; cyc(); start = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            cyc();
            checks++; if (out !== 16'(j - 1) || cycle_cnt !== 32'(j)) begin
                errors++; $display("FAIL disp_count: got out %0d cnt %0d expected out %0d cnt %0d", out, cycle_cnt, j - 1, j);
            end
        end
        halt = 1'b1; cyc(); halt = 1'b0;
        mode = 2'b00;
    endtask

    task automatic test_scan();
        for (int r = 0; r < NREGS; r++) regs[r] = $urandom;
        reset = 1'b1; mode = 2'b10; cyc(); reset = 1'b0;
        for (int j = 1; j <= 136; j++) begin
            cyc();
            checks++; if (scan_idx !== 5'((j / SCAN_DIV) % NREGS)) begin
                errors++; $display("FAIL scan_idx_%0d: got %0d expected %0d", j, scan_idx, (j / SCAN_DIV) % NREGS);
            end
            checks++; if (out !== regs[((j - 1) / SCAN_DIV) % NREGS][15:0]) begin
                errors++; $display("FAIL scan_out_%0d: got %0h expected %0h", j, out, regs[((j - 1) / SCAN_DIV) % NREGS][15:0]);
            end
        end
        mode = 2'b00; cyc();
        checks++; if (scan_idx !== 5'd0) begin errors++; $display("FAIL scan_leave: got %0d expected 0", scan_idx); end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        mode = 2'b11;
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 7; i++) cyc();
        checks++; if (cycle_cnt !== 32'd7) begin errors++; $display("FAIL mid_run_cnt: got %0d expected 7", cycle_cnt); end
        reset = 1'b1; cyc(); reset = 1'b0;
        checks++; if (state !== 2'b00 || cpu_en !== 1'b0 || cycle_cnt !== 32'd0 || out !== 16'h0) begin
            errors++; $display("FAIL mid_run_reset: got state %0d en %0b cnt %0d out %0h expected all 0", state, cpu_en, cycle_cnt, out);
        end
        mode = 2'b00;
    endtask

    task automatic test_saturation();
        do_reset();
        run_limit = 32'd0;
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 20; i++) cyc();
        checks++; if (cycle_cnt_sat !== 4'd15) begin errors++; $display("FAIL saturate_cnt: got %0d expected 15", cycle_cnt_sat); end
        checks++; if (state_sat !== 2'b01) begin errors++; $display("FAIL saturate_state: got %0d expected 1", state_sat); end
        halt = 1'b1; cyc(); halt = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            halt  = ($urandom_range(0, 99) < 4);
            start = ($urandom_range(0, 99) < 6);
            step  = ($urandom_range(0, 99) < 8);
            reset = ($urandom_range(0, 499) == 0);
            sw    = 5'($urandom);
            if ($urandom_range(0, 49) == 0) run_limit = $urandom_range(0, 25);
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom);
            cyc();
            checks++; if (state !== 2'(m_state) || cpu_en !== (m_state == 1 || m_state == 2)) begin
                errors++; $display("FAIL rand_state_%0d: got state %0d en %0b expected state %0d", i, state, cpu_en, m_state);
            end
            checks++; if (cycle_cnt !== m_cnt[31:0]) begin
                errors++; $display("FAIL rand_cnt_%0d: got %0d expected %0d", i, cycle_cnt, m_cnt);
            end
            checks++; if (out !== m_out) begin
                errors++; $display("FAIL rand_out_%0d: got %0h expected %0h", i, out, m_out);
            end
            checks++; if (scan_idx !== 5'((m_ticks / SCAN_DIV) % NREGS)) begin
                errors++; $display("FAIL rand_scan_%0d: got %0d expected %0d", i, scan_idx, (m_ticks / SCAN_DIV) % NREGS);
            end
        end
        reset = 1'b0; start = 1'b0; step = 1'b0; halt = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; step = 1'b0; halt = 1'b0;
        run_limit = 32'd0; sw = 5'd0; mode = 2'b00;
        m_state = 0; m_cnt = 0; m_out = '0; m_ticks = 0;
        for (int r = 0; r < NREGS; r++) regs[r] = $urandom;
        test_reset();
        test_free_run();
        test_bounded_run();
        test_step();
        test_display();
        test_scan();
        test_reset_mid_run();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
